// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: show-ahead sync FIFO, 2^AW entries of W bits, registered count.
// Ports: clk_sys, reset_n (async active-low), push/din, pop, dout (head, 0 when empty),
//        valid (not empty), drop (push refused because full and no pop this cycle).
module ps2_rx_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         drop
);
  localparam int D = 1 << AW;
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic full, do_push, do_pop;
  assign valid   = cnt != '0;
  assign full    = cnt == (AW+1)'(D);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  // Head is forced to 0 when empty so the output never shows stale or unwritten storage.
  assign dout    = valid ? mem[rd] : '0;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      wr  <= wr + AW'(do_push);
      rd  <= rd + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk_sys)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with scancode FIFO.
// Ports: clk_sys, reset_n (async active-low), ps2_clk/ps2_data (bridge stream, idle high),
//        rx_valid/rx_data/rx_ext/rx_rel (FIFO head), rx_ready (pop), frame_err and overflow
//        (1-cycle pulses), busy (mid-frame).
// Option: define PS2_RX_EXT_DECODE_EN to fold E0/F0 prefixes into rx_ext/rx_rel flags.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 24000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ext,
  output logic       rx_rel,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef PS2_RX_EXT_DECODE_EN
  localparam int W = 10;
`else
  localparam int W = 8;
`endif
  rx_state_t state, state_d;
  logic [1:0] clk_s, dat_s;
  logic clk_p, fall, d, to;
  logic [2:0] cnt, cnt_d;
  logic [7:0] sh, sh_d, byte_q;
  logic par, par_d, pok, pok_d, done, bad, push_q, err_q, fpush;
  logic [TW-1:0] tcnt;
  logic [W-1:0] fdin, fdout;
  assign d    = dat_s[1];
  assign fall = clk_p & ~clk_s[1];
  // A fall in the very cycle the limit is hit still counts as progress.
  assign to   = (state != IDLE) & ~fall & (tcnt == TW'(TIMEOUT - 1));
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
    par_d   = par;
    pok_d   = pok;
    done    = 1'b0;
    bad     = 1'b0;
    if (to) begin
      state_d = IDLE;
      bad     = 1'b1;
    end else if (fall)
      case (state)
        IDLE: if (!d) begin
          state_d = START;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
        START, DATA: begin
          sh_d    = {d, sh[7:1]};
          par_d   = par ^ d;
          cnt_d   = cnt + 3'd1;
          state_d = (cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          pok_d   = par ^ d;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          done    = d & pok;
          bad     = ~(d & pok);
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_s  <= 2'b11;
      dat_s  <= 2'b11;
      clk_p  <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      pok    <= 1'b0;
      tcnt   <= '0;
      push_q <= 1'b0;
      err_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_data};
      clk_p  <= clk_s[1];
      state  <= state_d;
      cnt    <= cnt_d;
      sh     <= sh_d;
      par    <= par_d;
      pok    <= pok_d;
      tcnt   <= (state == IDLE || fall) ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);
      push_q <= done;
      err_q  <= bad;
      byte_q <= sh;
    end
  assign frame_err = err_q;
`ifdef PS2_RX_EXT_DECODE_EN
  logic pe, pr, is_e, is_r;
  assign is_e   = byte_q == PS2_PFX_EXT;
  assign is_r   = byte_q == PS2_PFX_REL;
  assign fpush  = push_q & ~is_e & ~is_r;
  assign fdin   = {pe, pr, byte_q};
  assign rx_ext = fdout[9];
  assign rx_rel = fdout[8];
  // Flags clear on any real push attempt (even if it overflows) and on a bad frame.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      pe <= 1'b0;
      pr <= 1'b0;
    end else if (err_q | fpush) begin
      pe <= 1'b0;
      pr <= 1'b0;
    end else if (push_q) begin
      pe <= pe | is_e;
      pr <= pr | is_r;
    end
`else
  assign fpush  = push_q;
  assign fdin   = byte_q;
  assign rx_ext = 1'b0;
  assign rx_rel = 1'b0;
`endif
  assign rx_data = fdout[7:0];
  ps2_rx_fifo #(.W(W), .AW(FIFO_AW)) u_fifo (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .push(fpush),
    .din(fdin),
    .pop(rx_ready),
    .dout(fdout),
    .valid(rx_valid),
    .drop(overflow)
  );
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: self-checking bench for ps2_kbd_rx (frame-level scoreboard plus directed literals).
module tb_ps2_kbd_rx;
  localparam int TO = 120;
  localparam int H  = 4;
`ifdef PS2_RX_EXT_DECODE_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  logic clk_sys = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rx_ready = 1'b0;
  logic rx_valid, rx_ext, rx_rel, frame_err, overflow, busy;
  logic [7:0] rx_data;
  ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ext(rx_ext), .rx_rel(rx_rel),
    .rx_ready(rx_ready), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );
  initial forever #5 clk_sys = ~clk_sys;
  typedef struct {int due; bit err; bit [9:0] ent;} ev_t;
  ev_t evq[$];
  bit [9:0] mq[$];
  bit pe, pr;
  int cyc = 0, n_cmp = 0, n_bad = 0, ovf_seen = 0, err_seen = 0, rise_cyc = -1, err_cyc = -1;
  logic vprev = 1'b0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  // Drives the first nbits of a frame; registers the frame outcome with the scoreboard
  // the moment the stop bit falls. pp pops the full FIFO in the same cycle the byte is pushed.
  task automatic send(input logic [7:0] b, input bit flip, input bit stopv, input int nbits,
                      input bit pp, output int last);
    logic [10:0] f;
    f = {stopv, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (H) tick();
      ps2_clk = 1'b0;
      last = cyc;
      if (i == 10) begin
        if (flip || !stopv) begin
          evq.push_back('{last + 3, 1'b1, 10'd0});
          pe = 1'b0;
          pr = 1'b0;
        end else if (EXT && b == 8'hE0) pe = 1'b1;
        else if (EXT && b == 8'hF0) pr = 1'b1;
        else begin
          evq.push_back('{last + 3, 1'b0, {pe, pr, b}});
          pe = 1'b0;
          pr = 1'b0;
        end
      end
      for (int j = 1; j <= H; j++) begin
        tick();
        if (pp && i == 10 && j == 3) rx_ready = 1'b1;
        if (pp && i == 10 && j == 4) rx_ready = 1'b0;
      end
      ps2_clk = 1'b1;
    end
    if (nbits < 11) begin
      evq.push_back('{last + 3 + TO, 1'b1, 10'd0});
      pe = 1'b0;
      pr = 1'b0;
    end
    ps2_data = 1'b1;
    repeat (H) tick();
  endtask
  task automatic pop_expect(input logic [9:0] exp, input string nm);
    int k = 0;
    while (!rx_valid && k < 200) begin
      tick();
      k++;
    end
    chk({nm, "_valid"}, 32'(rx_valid), 32'd1);
    chk(nm, 32'({rx_ext, rx_rel, rx_data}), 32'(exp));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask
  // Scoreboard: every cycle the head, valid, and both pulses are compared with the model.
  bit c_pop, c_ps, c_er, c_drop;
  bit [9:0] c_ent;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      chk("reset_outputs", 32'({rx_valid, rx_data, rx_ext, rx_rel, frame_err, overflow, busy}), 32'd0);
      mq.delete();
      evq.delete();
    end else begin
      c_pop = rx_ready && mq.size() != 0;
      c_ps  = 1'b0;
      c_er  = 1'b0;
      c_ent = '0;
      if (evq.size() != 0 && evq[0].due == cyc) begin
        c_ps  = !evq[0].err;
        c_er  = evq[0].err;
        c_ent = evq[0].ent;
        void'(evq.pop_front());
      end
      c_drop = c_ps && mq.size() == 8 && !c_pop;
      chk("valid", 32'(rx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("head", 32'({rx_ext, rx_rel, rx_data}), 32'(mq[0]));
      chk("frame_err", 32'(frame_err), 32'(c_er));
      chk("overflow", 32'(overflow), 32'(c_drop));
      if (c_pop) void'(mq.pop_front());
      if (c_ps && !c_drop) mq.push_back(c_ent);
    end
    if (reset_n && rx_valid && !vprev) rise_cyc = cyc;
    if (reset_n && frame_err) begin
      err_cyc = cyc;
      err_seen++;
    end
    if (reset_n && overflow) ovf_seen++;
    vprev = rx_valid;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int last, e0, o0;
    repeat (3) tick();
    chk("reset_state", 32'({rx_valid, rx_data, rx_ext, rx_rel, frame_err, overflow, busy}), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    // Basic frame, latency and hold/pop.
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, last);
    chk("latency", 32'(rise_cyc), 32'(last + 4));
    repeat (10) tick();
    chk("hold_valid", 32'(rx_valid), 32'd1);
    chk("hold_data", 32'(rx_data), 32'h1C);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("pop_empty", 32'(rx_valid), 32'd0);
    // Parity error, then stop-bit error.
    e0 = err_seen;
    send(8'h1C, 1'b1, 1'b1, 11, 1'b0, last);
    chk("parity_err_count", 32'(err_seen), 32'(e0 + 1));
    chk("parity_no_push", 32'(rx_valid), 32'd0);
    chk("parity_idle", 32'(busy), 32'd0);
    send(8'h1C, 1'b0, 1'b0, 11, 1'b0, last);
    chk("stop_err_count", 32'(err_seen), 32'(e0 + 2));
    chk("stop_no_push", 32'(rx_valid), 32'd0);
    // Timeout after 4 data bits, then recovery.
    send(8'h33, 1'b0, 1'b1, 5, 1'b0, last);
    chk("to_busy", 32'(busy), 32'd1);
    repeat (TO + 10) tick();
    chk("to_err_cycle", 32'(err_cyc), 32'(last + 3 + TO));
    chk("to_err_count", 32'(err_seen), 32'(e0 + 3));
    chk("to_idle", 32'(busy), 32'd0);
    send(8'h2A, 1'b0, 1'b1, 11, 1'b0, last);
    pop_expect(10'h02A, "after_timeout");
    // Overflow: 9 frames into 8 entries, then push+pop while full.
    o0 = ovf_seen;
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b0, 1'b1, 11, 1'b0, last);
    chk("ovf_count", 32'(ovf_seen), 32'(o0 + 1));
    chk("ovf_head", 32'(rx_data), 32'h10);
    send(8'h30, 1'b0, 1'b1, 11, 1'b1, last);
    chk("ovf_pushpop_no_drop", 32'(ovf_seen), 32'(o0 + 1));
    for (int i = 1; i < 8; i++) pop_expect(10'(8'h10 + 8'(i)), "ovf_drain");
    pop_expect(10'h030, "ovf_tail");
    chk("ovf_empty", 32'(rx_valid), 32'd0);
    // Prefix handling.
    send(8'hE0, 1'b0, 1'b1, 11, 1'b0, last);
    send(8'hF0, 1'b0, 1'b1, 11, 1'b0, last);
    send(8'h75, 1'b0, 1'b1, 11, 1'b0, last);
    send(8'hF0, 1'b0, 1'b1, 11, 1'b0, last);
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, last);
    if (EXT) begin
      pop_expect(10'h375, "ext_e0_f0_75");
      pop_expect(10'h11C, "ext_f0_1c");
    end else begin
      pop_expect(10'h0E0, "raw_e0");
      pop_expect(10'h0F0, "raw_f0");
      pop_expect(10'h075, "raw_75");
      pop_expect(10'h0F0, "raw_f0b");
      pop_expect(10'h01C, "raw_1c");
    end
    chk("pfx_empty", 32'(rx_valid), 32'd0);
    // Reset mid-frame.
    send(8'h5A, 1'b0, 1'b1, 6, 1'b0, last);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    pe = 1'b0;
    pr = 1'b0;
    tick();
    chk("mid_reset_outputs", 32'({rx_valid, rx_data, rx_ext, rx_rel, frame_err, overflow, busy}), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send(8'h5A, 1'b0, 1'b1, 11, 1'b0, last);
    pop_expect(10'h05A, "after_reset");
    repeat (5) tick();
    chk("final_empty", 32'(rx_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
